// File: rtl/rx_frame_filter.sv
// rx_frame_filter: store-and-forward XGMII RX frame filter.
// Frames are written into a RAM FIFO speculatively and either committed or
// rolled back at Eof. Only committed words are replayed downstream over a
// valid/ready interface. Per-cause drop statistics are kept.
module rx_frame_filter #(
    parameter int ADDR_W  = 9,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InRxdv,
    input  logic [63:0] InRxd,
    input  logic        InRxSof,
    input  logic        InRxEof,
    input  logic [2:0]  InRxMod,
    input  logic [1:0]  InRxErr,
    output logic        OutRxdv,
    output logic [63:0] OutRxd,
    output logic        OutRxSof,
    output logic        OutRxEof,
    output logic [2:0]  OutRxMod,
    input  logic        OutRxRdy,
    input  logic        CntClr,
    output logic [31:0] GoodFrmCnt,
    output logic [31:0] CrcErrCnt,
    output logic [31:0] LenErrCnt,
    output logic [31:0] OvfDropCnt
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef logic [ADDR_W-1:0] ptr_t;
    localparam ptr_t ONE = ptr_t'(1);
    localparam logic [13:0] MIN_L = 14'(MIN_LEN);
    localparam logic [13:0] MAX_L = 14'(MAX_LEN);

    // Each entry holds {Sof, Eof, Mod, Data}
    logic [68:0] mem [DEPTH];

    ptr_t        wr_ptr, cmt_ptr, rd_ptr;
    logic        in_frame, ovf;
    logic [13:0] byte_cnt;

    logic        sof_w, accept, eof_w, abort, full, we, ovf_frm, len_bad;
    ptr_t        wr_addr;
    logic [3:0]  byte_add;
    logic [14:0] byte_sum;
    logic [13:0] byte_nxt;
    logic        drop_ovf, drop_err, drop_len, commit;

    logic        out_take, rd_en, mid_vld;
    logic [68:0] rd_q;

    // Write-side decode: target address, overflow, running length and verdict
    always_comb begin
        sof_w    = InRxdv & InRxSof;
        accept   = InRxdv & (InRxSof | in_frame);
        eof_w    = accept & InRxEof;
        abort    = sof_w & in_frame;
        // A new Sof restarts from the last committed position
        wr_addr  = sof_w ? cmt_ptr : wr_ptr;
        // Full is measured against the read pointer: words already lifted into
        // the output pipeline may be overwritten
        full     = ((wr_addr + ONE) == rd_ptr);
        we       = accept & ~full;
        ovf_frm  = (ovf & ~sof_w) | full;
        byte_add = (InRxEof && (InRxMod != 3'd0)) ? {1'b0, InRxMod} : 4'd8;
        byte_sum = {1'b0, (sof_w ? 14'd0 : byte_cnt)} + {11'd0, byte_add};
        byte_nxt = byte_sum[14] ? 14'h3fff : byte_sum[13:0];
        len_bad  = (byte_nxt < MIN_L) || (byte_nxt > MAX_L);
        drop_ovf = eof_w & ovf_frm;
        drop_err = eof_w & ~ovf_frm & (InRxErr != 2'b00);
        drop_len = eof_w & ~ovf_frm & (InRxErr == 2'b00) & len_bad;
        commit   = eof_w & ~ovf_frm & (InRxErr == 2'b00) & ~len_bad;
    end

    // Frame tracking: write pointer, commit pointer, overflow and byte count
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            cmt_ptr  <= '0;
            in_frame <= 1'b0;
            ovf      <= 1'b0;
            byte_cnt <= '0;
        end else if (accept) begin
            ovf      <= ovf_frm;
            byte_cnt <= byte_nxt;
            if (eof_w) begin
                in_frame <= 1'b0;
                if (commit) begin
                    wr_ptr  <= wr_addr + ONE;
                    cmt_ptr <= wr_addr + ONE;
                end else begin
                    wr_ptr  <= cmt_ptr;
                end
            end else begin
                in_frame <= 1'b1;
                wr_ptr   <= full ? wr_addr : wr_addr + ONE;
            end
        end
    end

    // Buffer RAM write port
    always_ff @(posedge Clk) begin
        if (we) mem[wr_addr] <= {InRxSof, InRxEof, InRxMod, InRxd};
    end

    // Read-side control: refill the RAM output stage whenever it will be free
    always_comb begin
        out_take = ~OutRxdv | OutRxRdy;
        rd_en    = (rd_ptr != cmt_ptr) & (~mid_vld | out_take);
    end

    // Registered RAM read; holds while the stage is stalled
    always_ff @(posedge Clk) begin
        if (rd_en) rd_q <= mem[rd_ptr];
    end

    // Read pointer, RAM-stage valid and output register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr   <= '0;
            mid_vld  <= 1'b0;
            OutRxdv  <= 1'b0;
            OutRxSof <= 1'b0;
            OutRxEof <= 1'b0;
            OutRxMod <= '0;
            OutRxd   <= '0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + ONE;
            mid_vld <= rd_en | (mid_vld & ~out_take);
            if (out_take) begin
                OutRxdv <= mid_vld;
                if (mid_vld) {OutRxSof, OutRxEof, OutRxMod, OutRxd} <= rd_q;
            end
        end
    end

    // Statistics; clear wins over any increment in the same cycle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            GoodFrmCnt <= '0;
            CrcErrCnt  <= '0;
            LenErrCnt  <= '0;
            OvfDropCnt <= '0;
        end else if (CntClr) begin
            GoodFrmCnt <= '0;
            CrcErrCnt  <= '0;
            LenErrCnt  <= '0;
            OvfDropCnt <= '0;
        end else begin
            GoodFrmCnt <= GoodFrmCnt + 32'(commit);
            CrcErrCnt  <= CrcErrCnt + 32'(drop_err);
            OvfDropCnt <= OvfDropCnt + 32'(drop_ovf);
            // An abort and a length drop can both land on one Sof+Eof word
            LenErrCnt  <= LenErrCnt + 32'(abort) + 32'(drop_len);
        end
    end
endmodule

// File: tb/tb_rx_frame_filter.sv
// Directed bench for rx_frame_filter: a full-size instance checked against a
// word queue of expected output, plus an ADDR_W=4 instance for overflow.
module tb_rx_frame_filter;
    logic        Clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxdv = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
    logic [63:0] rxd = '0;
    logic [2:0]  rx_mod = '0;
    logic [1:0]  rx_err = '0;
    logic        rdy_m = 1'b1, rdy_s = 1'b1, cnt_clr = 1'b0;
    logic        rnd_rdy = 1'b0;

    logic        vld_m, sof_m, eof_m, vld_s, sof_s, eof_s;
    logic [63:0] d_m, d_s;
    logic [2:0]  mod_m, mod_s;
    logic [31:0] good_m, crc_m, len_m, ovf_m, good_s, crc_s, len_s, ovf_s;

    int n_chk = 0, n_err = 0, fid = 0;
    logic [68:0] exp_q[$], exp_s[$], obs_s[$];
    logic [69:0] prev_w;
    logic        hold_prev = 1'b0;

    always #5 Clk = ~Clk;

    rx_frame_filter dut (
        .Clk(Clk), .Reset(rst), .InRxdv(rxdv), .InRxd(rxd), .InRxSof(rx_sof),
        .InRxEof(rx_eof), .InRxMod(rx_mod), .InRxErr(rx_err),
        .OutRxdv(vld_m), .OutRxd(d_m), .OutRxSof(sof_m), .OutRxEof(eof_m),
        .OutRxMod(mod_m), .OutRxRdy(rdy_m), .CntClr(cnt_clr),
        .GoodFrmCnt(good_m), .CrcErrCnt(crc_m), .LenErrCnt(len_m), .OvfDropCnt(ovf_m)
    );

    rx_frame_filter #(.ADDR_W(4)) dut_s (
        .Clk(Clk), .Reset(rst), .InRxdv(rxdv), .InRxd(rxd), .InRxSof(rx_sof),
        .InRxEof(rx_eof), .InRxMod(rx_mod), .InRxErr(rx_err),
        .OutRxdv(vld_s), .OutRxd(d_s), .OutRxSof(sof_s), .OutRxEof(eof_s),
        .OutRxMod(mod_s), .OutRxRdy(rdy_s), .CntClr(cnt_clr),
        .GoodFrmCnt(good_s), .CrcErrCnt(crc_s), .LenErrCnt(len_s), .OvfDropCnt(ovf_s)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Scoreboard for the main instance plus hold-stability, sampled mid-cycle
    initial forever begin
        @(negedge Clk);
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) chk("hold", {vld_m, sof_m, eof_m, mod_m, d_m}, prev_w);
            if (vld_m && rdy_m)
                chk("word", {sof_m, eof_m, mod_m, d_m},
                    (exp_q.size() != 0) ? exp_q.pop_front() : {69{1'b1}});
            prev_w    = {vld_m, sof_m, eof_m, mod_m, d_m};
            hold_prev = vld_m & ~rdy_m;
            if (vld_s && rdy_s) obs_s.push_back({sof_s, eof_s, mod_s, d_s});
        end
    end

    // Random backpressure for the main instance
    initial forever begin
        @(posedge Clk); #1;
        if (rnd_rdy) rdy_m = ($urandom_range(0, 3) != 0);
    end

    task automatic drv(input logic s, input logic e, input logic [2:0] m,
                       input logic [1:0] er, input logic [63:0] d);
        rxdv = 1'b1; rx_sof = s; rx_eof = e; rx_mod = m; rx_err = er; rxd = d;
        @(posedge Clk); #1;
        rxdv = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_mod = '0; rx_err = '0;
    endtask

    task automatic send_frame(input int nbytes, input logic [1:0] er,
                              input bit push_m, input bit push_s);
        int nw;
        logic [2:0] md;
        logic [63:0] d;
        logic s, e;
        nw = (nbytes + 7) / 8;
        md = 3'(nbytes % 8);
        fid++;
        for (int w = 0; w < nw; w++) begin
            s = (w == 0);
            e = (w == nw - 1);
            d = {32'(fid), 32'(w) ^ 32'h5EED_0000};
            if (push_m) exp_q.push_back({s, e, (e ? md : 3'd0), d});
            if (push_s) exp_s.push_back({s, e, (e ? md : 3'd0), d});
            drv(s, e, e ? md : 3'd0, e ? er : 2'b00, d);
        end
    endtask

    task automatic send_partial(input int nw);
        fid++;
        for (int w = 0; w < nw; w++) drv(w == 0, 1'b0, 3'd0, 2'b00, {32'(fid), 32'(w)});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        for (int k = 0; k < bound && exp_q.size() != 0; k++) idle(1);
        idle(4);
        chk(tag, 72'(exp_q.size()), 72'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        exp_q.delete(); exp_s.delete(); obs_s.delete();
        rdy_m = 1'b1; rdy_s = 1'b1;
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        idle(1);
        do_reset();
        // Reset state
        chk("rst_vld", {vld_m, sof_m, eof_m}, 3'b000);
        chk("rst_d", d_m, 64'd0);
        chk("rst_cnt", {good_m, crc_m, len_m, ovf_m}, 128'd0);

        // 1: 64-byte frame, latency and pass-through
        send_frame(64, 2'b00, 1, 0);
        chk("lat_e0", vld_m, 1'b0);
        idle(1);
        chk("lat_e1", vld_m, 1'b0);
        idle(1);
        chk("lat_e2", {vld_m, sof_m}, 2'b11);
        wait_drain("t1_drain", 100);
        chk("t1_good", good_m, 32'd1);

        // 2: CRC error dropped, following good frame intact
        do_reset();
        send_frame(100, 2'b01, 0, 0);
        send_frame(80, 2'b00, 1, 0);
        wait_drain("t2_drain", 100);
        chk("t2_crc", crc_m, 32'd1);
        chk("t2_good", good_m, 32'd1);

        // 3: runt and giant dropped; exactly MAX_LEN kept
        do_reset();
        send_frame(60, 2'b00, 0, 0);
        send_frame(1519, 2'b00, 0, 0);
        idle(10);
        chk("t3_len", len_m, 32'd2);
        chk("t3_good0", good_m, 32'd0);
        send_frame(1518, 2'b00, 1, 0);
        wait_drain("t3_drain", 400);
        chk("t3_good1", good_m, 32'd1);

        // 4: small buffer stalled downstream overflows on 200-byte frame
        do_reset();
        rdy_s = 1'b0;
        send_frame(64, 2'b00, 1, 1);
        send_frame(64, 2'b00, 1, 1);
        send_frame(200, 2'b00, 1, 0);
        idle(5);
        chk("t4_ovf", ovf_s, 32'd1);
        chk("t4_good", good_s, 32'd2);
        rdy_s = 1'b1;
        wait_drain("t4_drain", 100);
        idle(20);
        chk("t4_nwords", 72'(obs_s.size()), 72'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++)
            chk("t4_word", obs_s[i], exp_s[i]);

        // 5: Sof mid-frame aborts the first frame
        do_reset();
        send_partial(5);
        send_frame(64, 2'b00, 1, 0);
        wait_drain("t5_drain", 100);
        chk("t5_len", len_m, 32'd1);
        chk("t5_good", good_m, 32'd1);

        // 6: 1000 back-to-back legal frames under random backpressure
        do_reset();
        rnd_rdy = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            for (int k = 0; k < 2000 && exp_q.size() > 200; k++) idle(1);
            send_frame($urandom_range(64, 160), 2'b00, 1, 0);
        end
        wait_drain("t6_drain", 2000);
        rnd_rdy = 1'b0;
        idle(2);
        rdy_m = 1'b1;
        chk("t6_good", good_m, 32'd1000);
        chk("t6_drop", {crc_m, len_m, ovf_m}, 96'd0);

        // Counter clear
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        chk("clr_good", good_m, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
